// File: rtl/nes_bus_pkg.sv
// Shared types and register addresses for the NES CPU bus and the sprite DMA sequencer.
//   dma_state_t  - sequencer states (IDLE, HALT, ALIGN, READ, WRITE)
//   REG_OAMDMA   - CPU write address that starts a sprite transfer
//   REG_OAMDATA  - PPU OAM data port, destination of every DMA write
//   idx_width()  - byte-index counter width for a given transfer length (never below 1)
package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] REG_OAMDMA  = 16'h4014;
    localparam logic [15:0] REG_OAMDATA = 16'h2004;

    // $clog2(1) is 0, which would give a zero-width counter.
    function automatic int unsigned idx_width(input int unsigned count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

endpackage

// File: rtl/nes_bus_if.sv
// CPU core / shared bus bundle seen by the sprite DMA controller.
//   master - CPU core and bus side: drives cpu_* and bus_data_in, observes rdy and bus_*
//   slave  - controller side: observes cpu_* and bus_data_in, drives rdy and bus_*
interface nes_bus_if;

    logic [15:0] cpu_address;
    logic [7:0]  cpu_data_out;
    logic        cpu_rw;
    logic [7:0]  bus_data_in;
    logic        rdy;
    logic [15:0] bus_address;
    logic [7:0]  bus_data_out;
    logic        bus_rw;

    modport master (
        output cpu_address, cpu_data_out, cpu_rw, bus_data_in,
        input  rdy, bus_address, bus_data_out, bus_rw
    );

    modport slave (
        input  cpu_address, cpu_data_out, cpu_rw, bus_data_in,
        output rdy, bus_address, bus_data_out, bus_rw
    );

endinterface

// File: rtl/cpu_bus_mux.sv
// Combinational owner select for the shared bus: the CPU core when i_dma_sel is low,
// the DMA sequencer when it is high.
//   i_dma_sel                               - DMA owns the bus
//   i_cpu_address/i_cpu_data/i_cpu_rw       - CPU core outputs
//   i_dma_address/i_dma_data/i_dma_rw       - DMA sequencer outputs
//   o_bus_address/o_bus_data/o_bus_rw       - shared bus drive
module cpu_bus_mux (
    input  logic        i_dma_sel,
    input  logic [15:0] i_cpu_address,
    input  logic [7:0]  i_cpu_data,
    input  logic        i_cpu_rw,
    input  logic [15:0] i_dma_address,
    input  logic [7:0]  i_dma_data,
    input  logic        i_dma_rw,
    output logic [15:0] o_bus_address,
    output logic [7:0]  o_bus_data,
    output logic        o_bus_rw
);

    always_comb begin
        o_bus_address = i_cpu_address;
        o_bus_data    = i_cpu_data;
        o_bus_rw      = i_cpu_rw;
        if (i_dma_sel) begin
            o_bus_address = i_dma_address;
            o_bus_data    = i_dma_data;
            o_bus_rw      = i_dma_rw;
        end
    end

endmodule

// File: rtl/oam_dma_controller.sv
// Sprite DMA sequencer and owner of the shared CPU bus. A CPU write to DMA_TRIGGER_ADDR
// halts the CPU and copies BYTE_COUNT bytes from page {data,8'h00} to OAM_DATA_ADDR,
// alternating read and write CPU cycles. When idle the CPU passes straight through.
//   i_clock       - system clock
//   i_reset_n     - asynchronous active-low reset
//   i_cpu_ce      - one-clock pulse per CPU cycle; all state advances only on it
//   io_bus        - CPU core inputs, bus read data, rdy and shared bus outputs
//   o_dma_active  - controller owns the bus
//   o_dma_done    - one-clock pulse after the last byte is written
module oam_dma_controller
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_TRIGGER_ADDR = REG_OAMDMA,
    parameter logic [15:0] OAM_DATA_ADDR    = REG_OAMDATA,
    parameter int unsigned BYTE_COUNT       = 256
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic        i_cpu_ce,
    nes_bus_if.slave    io_bus,
    output logic        o_dma_active,
    output logic        o_dma_done
);

    localparam int unsigned      IDX_W    = idx_width(BYTE_COUNT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTE_COUNT - 1);

    dma_state_t       r_state, w_state_next;
    logic             r_parity;
    logic [7:0]       r_page, w_page_next;
    logic [IDX_W-1:0] r_index, w_index_next;
    logic [7:0]       r_byte, w_byte_next;
    logic             r_dma_done, w_done_next;

    logic             w_trigger;
    logic             w_dma_active;
    logic [15:0]      w_dma_address;
    logic             w_dma_rw;

    assign w_trigger = !io_bus.cpu_rw && (io_bus.cpu_address == DMA_TRIGGER_ADDR);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_parity   <= 1'b0;
            r_page     <= 8'h00;
            r_index    <= '0;
            r_byte     <= 8'h00;
            r_dma_done <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_page     <= w_page_next;
            r_index    <= w_index_next;
            r_byte     <= w_byte_next;
            // Not gated by cpu_ce so the done flag lasts exactly one system clock.
            r_dma_done <= w_done_next;
            if (i_cpu_ce) begin
                r_parity <= ~r_parity;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_page_next   = r_page;
        w_index_next  = r_index;
        w_byte_next   = r_byte;
        w_done_next   = 1'b0;
        // HALT and ALIGN are dummy reads at whatever address the stalled CPU presents.
        w_dma_address = io_bus.cpu_address;
        w_dma_rw      = 1'b1;

        unique case (r_state)
            IDLE: begin
                if (i_cpu_ce && w_trigger) begin
                    w_page_next  = io_bus.cpu_data_out;
                    w_index_next = '0;
                    w_state_next = HALT;
                end
            end
            HALT: begin
                // Parity is 1 now means the following cycle is a get cycle, so read directly.
                if (i_cpu_ce) begin
                    w_state_next = r_parity ? READ : ALIGN;
                end
            end
            ALIGN: begin
                if (i_cpu_ce) begin
                    w_state_next = READ;
                end
            end
            READ: begin
                w_dma_address = {r_page, 8'(r_index)};
                if (i_cpu_ce) begin
                    w_byte_next  = io_bus.bus_data_in;
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                w_dma_address = OAM_DATA_ADDR;
                w_dma_rw      = 1'b0;
                if (i_cpu_ce) begin
                    if (r_index == LAST_IDX) begin
                        w_done_next  = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_index_next = r_index + IDX_W'(1);
                        w_state_next = READ;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_dma_active = (r_state != IDLE);
    assign o_dma_active = w_dma_active;
    assign o_dma_done   = r_dma_done;
    assign io_bus.rdy   = !w_dma_active;

    cpu_bus_mux u_cpu_bus_mux (
        .i_dma_sel     (w_dma_active),
        .i_cpu_address (io_bus.cpu_address),
        .i_cpu_data    (io_bus.cpu_data_out),
        .i_cpu_rw      (io_bus.cpu_rw),
        .i_dma_address (w_dma_address),
        .i_dma_data    (r_byte),
        .i_dma_rw      (w_dma_rw),
        .o_bus_address (io_bus.bus_address),
        .o_bus_data    (io_bus.bus_data_out),
        .o_bus_rw      (io_bus.bus_rw)
    );

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller: idle passthrough, even/odd-start transfers,
// mid-transfer reset, page $FF with sparse cpu_ce, and non-trigger accesses.
module tb_oam_dma_controller;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ce = 1'b0;
    logic dma_active;
    logic dma_done;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    int par = 0;  // expected parity of the current CPU cycle

    nes_bus_if bus_if ();

    oam_dma_controller dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_cpu_ce     (ce),
        .io_bus       (bus_if.slave),
        .o_dma_active (dma_active),
        .o_dma_done   (dma_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (dma_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_cpu(input logic [15:0] a, input logic [7:0] d, input logic rw);
        bus_if.cpu_address  = a;
        bus_if.cpu_data_out = d;
        bus_if.cpu_rw       = rw;
        #1;
    endtask

    // Idle clocks without cpu_ce, then one CPU cycle; returns 1 time unit after the edge.
    task automatic pulse(input int gap, input logic [15:0] hold_addr);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk);
            #1;
            if (g == gap - 1) check("gap_hold_addr", bus_if.bus_address, hold_addr);
        end
        ce = 1'b1;
        @(posedge clk);
        #1;
        ce = 1'b0;
        par ^= 1;
    endtask

    task automatic align_par(input int p);
        if (par != p) begin
            set_cpu(16'h8000, 8'h00, 1'b1);
            pulse(0, 16'h8000);
        end
    endtask

    task automatic idle_cycle(input string tag, input logic [15:0] a, input logic [7:0] d,
                              input logic rw);
        set_cpu(a, d, rw);
        check({tag, "_addr"}, bus_if.bus_address, a);
        check({tag, "_rw"}, bus_if.bus_rw, rw);
        if (!rw) check({tag, "_data"}, bus_if.bus_data_out, d);
        pulse(0, a);
        check({tag, "_rdy"}, bus_if.rdy, 1'b1);
        check({tag, "_active"}, dma_active, 1'b0);
    endtask

    // Full 256-byte transfer; exp_cycles is 513 (no ALIGN) or 514 (with ALIGN).
    task automatic run_dma(input logic [7:0] page, input int gap, input int exp_cycles,
                           input int abort_at);
        int cyc = 0;
        int d0 = done_cnt;
        logic [7:0] v;
        set_cpu(16'h4014, page, 1'b0);
        check("trig_addr", bus_if.bus_address, 16'h4014);
        check("trig_rw", bus_if.bus_rw, 1'b0);
        check("trig_rdy", bus_if.rdy, 1'b1);
        pulse(gap, 16'h4014);
        // A stalled CPU presenting a write, including another trigger, must be ignored.
        set_cpu(16'h1234, 8'hAA, 1'b0);
        for (int k = 0; k < exp_cycles - 512; k++) begin
            check("dummy_addr", bus_if.bus_address, 16'h1234);
            check("dummy_rw", bus_if.bus_rw, 1'b1);
            check("dummy_active", dma_active, 1'b1);
            if (bus_if.rdy === 1'b0) cyc++;
            pulse(gap, 16'h1234);
        end
        for (int i = 0; i < 256; i++) begin
            v = 8'(i * 37) + page;
            bus_if.bus_data_in = v;
            #1;
            check("rd_addr", bus_if.bus_address, {page, 8'(i)});
            check("rd_rw", bus_if.bus_rw, 1'b1);
            if (i == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_rdy", bus_if.rdy, 1'b1);
                check("rst_active", dma_active, 1'b0);
                check("rst_pass_rw", bus_if.bus_rw, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                par = 0;
                @(posedge clk);
                #1;
                check("rst_no_done", done_cnt - d0, 0);
                return;
            end
            if (bus_if.rdy === 1'b0) cyc++;
            pulse(gap, {page, 8'(i)});
            bus_if.bus_data_in = ~v;  // the latched byte must not follow the bus
            #1;
            check("wr_addr", bus_if.bus_address, 16'h2004);
            check("wr_rw", bus_if.bus_rw, 1'b0);
            check("wr_data", bus_if.bus_data_out, v);
            if (bus_if.rdy === 1'b0) cyc++;
            pulse(gap, 16'h2004);
        end
        check("end_rdy", bus_if.rdy, 1'b1);
        check("end_active", dma_active, 1'b0);
        check("cycles", cyc, exp_cycles);
        @(negedge clk);
        #1;
        check("done_pulses", done_cnt - d0, 1);
    endtask

    initial begin
        bus_if.bus_data_in = 8'h00;
        set_cpu(16'hC000, 8'h12, 1'b1);
        check("reset_rdy", bus_if.rdy, 1'b1);
        check("reset_active", dma_active, 1'b0);
        check("reset_done", dma_done, 1'b0);
        check("reset_pass_addr", bus_if.bus_address, 16'hC000);
        #6;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Idle passthrough
        idle_cycle("pass_rd", 16'h8000, 8'h00, 1'b1);
        idle_cycle("pass_wr", 16'h0300, 8'h55, 1'b0);

        // Even start: HALT then READ
        align_par(0);
        run_dma(8'h02, 0, 513, -1);

        // Odd start: HALT, ALIGN, then READ
        align_par(1);
        run_dma(8'h03, 0, 514, -1);

        // Reset at byte 100, then a fresh transfer starts from index 0
        align_par(0);
        run_dma(8'h04, 0, 513, 100);
        align_par(1);
        run_dma(8'h05, 0, 514, -1);

        // Page $FF with cpu_ce high one clock in twelve
        align_par(0);
        run_dma(8'hFF, 11, 513, -1);

        // Non-trigger accesses
        idle_cycle("nt_4015", 16'h4015, 8'h02, 1'b0);
        idle_cycle("nt_2004", 16'h2004, 8'h02, 1'b0);
        idle_cycle("nt_rd4014", 16'h4014, 8'h02, 1'b1);
        idle_cycle("nt_after", 16'h8000, 8'h00, 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
